// File: rtl/cu_flush_seq.sv
// cu_flush_seq: commit-side flush/serialisation sequencer.
// Accepts one serialising event at a time (exception, mispredict, FENCE,
// FENCE.I, SFENCE.VMA). It then walks through pipeline flush, MSHR/register
// clears, memory drain, L1D->L2 sync and TLB flush, as the event requires.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   ev_*                    event handshake and operands from commit
//   inflight_i              outstanding LSQ/d-cache operations
//   l2c_update_done_i       L1D->L2 update complete
//   flush_o/stall_o/abort_o pipeline control
//   clr_o                   clear strobes (0: L1 TLB MSHR, 1: L2 TLB MSHR, 2: d-MSHR/regs)
//   synch_l1dc_l2c_o        L1D->L2 sync request
//   L1TLB/L2TLB_flush_type_o, flush_asid_o, flush_page_o  TLB flush command
//   done_o                  end-of-sequence pulse
//   err_o                   sticky sync-timeout flag

package cu_flush_seq_pkg;
    typedef logic [4:0]  except_code_t;
    typedef logic [15:0] asid_t;
    typedef logic [26:0] vpn_t;

    typedef enum logic [1:0] {
        NoFlush   = 2'd0,
        FlushPage = 2'd1,
        FlushASID = 2'd2,
        FlushAll  = 2'd3
    } tlb_flush_e;

    typedef enum logic [2:0] {
        EV_EXCEPT     = 3'd0,
        EV_MISPRED    = 3'd1,
        EV_FENCE      = 3'd2,
        EV_FENCE_I    = 3'd3,
        EV_SFENCE_VMA = 3'd4
    } ev_type_e;

    localparam except_code_t E_I_ADDR_MISALIGNED   = 5'd0;
    localparam except_code_t E_I_ACCESS_FAULT      = 5'd1;
    localparam except_code_t E_ILLEGAL_INSTRUCTION = 5'd2;
    localparam except_code_t E_BREAKPOINT          = 5'd3;
    localparam except_code_t E_LD_ADDR_MISALIGNED  = 5'd4;
    localparam except_code_t E_LD_ACCESS_FAULT     = 5'd5;
    localparam except_code_t E_ST_ADDR_MISALIGNED  = 5'd6;
    localparam except_code_t E_ST_ACCESS_FAULT     = 5'd7;
    localparam except_code_t E_ENV_CALL_UMODE      = 5'd8;
    localparam except_code_t E_INSTR_PAGE_FAULT    = 5'd12;
    localparam except_code_t E_LD_PAGE_FAULT       = 5'd13;
    localparam except_code_t E_ST_PAGE_FAULT       = 5'd15;
endpackage

module cu_flush_seq
    import cu_flush_seq_pkg::*;
#(
    parameter int unsigned N_CLR        = 3,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SYNC_TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ev_valid_i,
    output logic             ev_ready_o,
    input  logic [2:0]       ev_type_i,
    input  except_code_t     ev_code_i,
    input  asid_t            ev_asid_i,
    input  vpn_t             ev_vpn_i,
    input  logic             ev_rs1_zero_i,
    input  logic             ev_rs2_zero_i,
    input  logic [CNT_W-1:0] inflight_i,
    input  logic             l2c_update_done_i,
    output logic             flush_o,
    output logic             stall_o,
    output logic             abort_o,
    output logic [N_CLR-1:0] clr_o,
    output logic             synch_l1dc_l2c_o,
    output tlb_flush_e       L1TLB_flush_type_o,
    output tlb_flush_e       L2TLB_flush_type_o,
    output asid_t            flush_asid_o,
    output vpn_t             flush_page_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_FLUSH, S_DRAIN, S_SYNC, S_TLB, S_DONE
    } state_e;

    // Flush counter only needs to hold FLUSH_CYCLES-1; sync counter is
    // sized so that SYNC_TIMEOUT itself is representable.
    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned TO_W = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = (SYNC_TIMEOUT > 0) ? TO_W'(SYNC_TIMEOUT - 1) : '0;

    state_e            state;
    ev_type_e          type_q;
    except_code_t      code_q;
    asid_t             asid_q;
    vpn_t              vpn_q;
    logic              rs1z_q;
    logic              rs2z_q;
    logic [FC_W-1:0]   flush_cnt;
    logic [TO_W-1:0]   sync_cnt;

    // Reserved type encodings fall back to EXCEPT.
    function automatic ev_type_e norm_type(input logic [2:0] t);
        return (t > 3'd4) ? EV_EXCEPT : ev_type_e'(t);
    endfunction

    function automatic logic [N_CLR-1:0] clr_sel(input ev_type_e t, input except_code_t c);
        logic [N_CLR-1:0] m;
        m = '0;
        case (t)
            EV_EXCEPT: begin
                case (c)
                    E_I_ADDR_MISALIGNED, E_I_ACCESS_FAULT, E_INSTR_PAGE_FAULT: begin
                        m[0] = 1'b1;
                        m[1] = 1'b1;
                    end
                    E_LD_ADDR_MISALIGNED, E_LD_ACCESS_FAULT, E_LD_PAGE_FAULT,
                    E_ST_ADDR_MISALIGNED, E_ST_ACCESS_FAULT, E_ST_PAGE_FAULT:
                        m[2] = 1'b1;
                    default: ;
                endcase
            end
            EV_FENCE_I: begin
                m[0] = 1'b1;
                m[1] = 1'b1;
            end
            EV_SFENCE_VMA: m = '1;
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic abort_sel(input ev_type_e t, input except_code_t c);
        return (t == EV_EXCEPT) && (c == E_ILLEGAL_INSTRUCTION);
    endfunction

    // Outputs are registered alongside the state: each transition loads the
    // output values belonging to the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= S_INIT;
            type_q             <= EV_EXCEPT;
            code_q             <= '0;
            asid_q             <= '0;
            vpn_q              <= '0;
            rs1z_q             <= 1'b0;
            rs2z_q             <= 1'b0;
            flush_cnt          <= '0;
            sync_cnt           <= '0;
            ev_ready_o         <= 1'b0;
            flush_o            <= 1'b1;
            stall_o            <= 1'b0;
            abort_o            <= 1'b0;
            clr_o              <= '1;
            synch_l1dc_l2c_o   <= 1'b0;
            L1TLB_flush_type_o <= FlushAll;
            L2TLB_flush_type_o <= FlushAll;
            flush_asid_o       <= '0;
            flush_page_o       <= '0;
            done_o             <= 1'b0;
            err_o              <= 1'b0;
        end else begin
            ev_ready_o         <= 1'b0;
            flush_o            <= 1'b0;
            stall_o            <= 1'b0;
            abort_o            <= 1'b0;
            clr_o              <= '0;
            synch_l1dc_l2c_o   <= 1'b0;
            L1TLB_flush_type_o <= NoFlush;
            L2TLB_flush_type_o <= NoFlush;
            flush_asid_o       <= '0;
            flush_page_o       <= '0;
            done_o             <= 1'b0;

            case (state)
                S_INIT: begin
                    state      <= S_IDLE;
                    ev_ready_o <= 1'b1;
                end

                S_IDLE: begin
                    if (ev_valid_i) begin
                        state     <= S_FLUSH;
                        type_q    <= norm_type(ev_type_i);
                        code_q    <= ev_code_i;
                        asid_q    <= ev_asid_i;
                        vpn_q     <= ev_vpn_i;
                        rs1z_q    <= ev_rs1_zero_i;
                        rs2z_q    <= ev_rs2_zero_i;
                        flush_cnt <= FC_LAST;
                        flush_o   <= 1'b1;
                        stall_o   <= 1'b1;
                        clr_o     <= clr_sel(norm_type(ev_type_i), ev_code_i);
                        abort_o   <= abort_sel(norm_type(ev_type_i), ev_code_i);
                    end else begin
                        ev_ready_o <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        if (type_q == EV_EXCEPT || type_q == EV_MISPRED) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state   <= S_DRAIN;
                            stall_o <= 1'b1;
                        end
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                        flush_o   <= 1'b1;
                        stall_o   <= 1'b1;
                        clr_o     <= clr_sel(type_q, code_q);
                        abort_o   <= abort_sel(type_q, code_q);
                    end
                end

                S_DRAIN: begin
                    if (inflight_i == '0) begin
                        if (type_q == EV_FENCE) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state            <= S_SYNC;
                            sync_cnt         <= '0;
                            stall_o          <= 1'b1;
                            synch_l1dc_l2c_o <= 1'b1;
                        end
                    end else begin
                        stall_o <= 1'b1;
                    end
                end

                S_SYNC: begin
                    if (l2c_update_done_i ||
                        ((SYNC_TIMEOUT != 0) && (sync_cnt == TO_LAST))) begin
                        // A completion in the last allowed cycle is not an error.
                        if (!l2c_update_done_i)
                            err_o <= 1'b1;
                        if (type_q == EV_SFENCE_VMA) begin
                            state   <= S_TLB;
                            stall_o <= 1'b1;
                            if (rs1z_q) begin
                                if (rs2z_q) begin
                                    L1TLB_flush_type_o <= FlushAll;
                                    L2TLB_flush_type_o <= FlushAll;
                                end else begin
                                    L1TLB_flush_type_o <= FlushASID;
                                    L2TLB_flush_type_o <= FlushASID;
                                    flush_asid_o       <= asid_q;
                                end
                            end else begin
                                L1TLB_flush_type_o <= FlushPage;
                                L2TLB_flush_type_o <= FlushPage;
                                flush_page_o       <= vpn_q;
                                flush_asid_o       <= rs2z_q ? '0 : asid_q;
                            end
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end else begin
                        sync_cnt         <= sync_cnt + 1'b1;
                        stall_o          <= 1'b1;
                        synch_l1dc_l2c_o <= 1'b1;
                    end
                end

                S_TLB: begin
                    state  <= S_DONE;
                    done_o <= 1'b1;
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    ev_ready_o <= 1'b1;
                end

                default: begin
                    state              <= S_INIT;
                    flush_o            <= 1'b1;
                    clr_o              <= '1;
                    L1TLB_flush_type_o <= FlushAll;
                    L2TLB_flush_type_o <= FlushAll;
                end
            endcase
        end
    end

endmodule
